pipe_stall_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipe_stall_ctrl_pkg.sv | 33 +++
 rtl/pipe_scoreboard.sv | 68 ++++++
 rtl/pipe_stall_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types, defaults and helpers for the pipeline stall/flush sequencer.
package pipe_stall_ctrl_pkg;

   localparam int unsigned PSC_RF_ADDR_W   = 5;
   localparam int unsigned PSC_LU_DEPTH    = 2;
   localparam int unsigned PSC_TRAP_CYCLES = 2;

   typedef enum logic [1:0] {
      PSC_RUN        = 2'd0,
      PSC_MEM_WAIT   = 2'd1,
      PSC_TRAP_FLUSH = 2'd2
   } psc_state_e;

   // Per-stage hold/bubble controls produced each cycle by the sequencer.
   typedef struct packed {
      logic pc_stall;
      logic ifid_stall;
      logic ifid_flush;
      logic idex_stall;
      logic idex_flush;
      logic exmem_stall;
      logic exmem_flush;
      logic memwb_stall;
      logic lu_issue;
      logic lu_kill;
   } stage_ctrl_t;

   // Counter width that is at least one bit even for a range of 0..0.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Pending-write scoreboard for long-latency unit results plus the ID hazard compare.
module pipe_scoreboard
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int unsigned RF_ADDR_WIDTH = PSC_RF_ADDR_W,
   parameter int unsigned LU_DEPTH      = PSC_LU_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_clear,
   input  logic                     i_issue,
   input  logic                     i_done,
   input  logic [RF_ADDR_WIDTH-1:0] i_done_rd,
   input  logic [RF_ADDR_WIDTH-1:0] i_rs1_addr,
   input  logic [RF_ADDR_WIDTH-1:0] i_rs2_addr,
   input  logic [RF_ADDR_WIDTH-1:0] i_rs3_addr,
   input  logic [RF_ADDR_WIDTH-1:0] i_rd_addr,
   input  logic                     i_rd_wen,
   input  logic                     i_lu_op,
   output logic                     o_hazard,
   output logic                     o_busy
);

   localparam int unsigned NUM_REGS = 1 << RF_ADDR_WIDTH;
   localparam int unsigned CNT_W    = cnt_width(LU_DEPTH);

   logic [NUM_REGS-1:0] r_pend;
   logic [CNT_W-1:0]    r_lu_cnt;

   logic                w_done_ok;
   logic                w_full;
   logic [NUM_REGS-1:0] w_clr_mask;
   logic [NUM_REGS-1:0] w_set_mask;
   logic [NUM_REGS-1:0] w_pend_eff;

   // A write-back only counts when something is in flight for that register.
   assign w_done_ok  = i_done && (r_lu_cnt != '0) && r_pend[i_done_rd];
   assign w_clr_mask = w_done_ok ? (NUM_REGS'(1) << i_done_rd) : '0;
   assign w_set_mask = (i_issue && (i_rd_addr != '0)) ? (NUM_REGS'(1) << i_rd_addr) : '0;
   // Write-back this cycle releases dependants in the same cycle.
   assign w_pend_eff = r_pend & ~w_clr_mask;
   assign w_full     = (r_lu_cnt == CNT_W'(LU_DEPTH));

   // RAW on any source, WAW on the destination, or no free long-latency slot.
   assign o_hazard = ((i_rs1_addr != '0) && w_pend_eff[i_rs1_addr])
                   | ((i_rs2_addr != '0) && w_pend_eff[i_rs2_addr])
                   | ((i_rs3_addr != '0) && w_pend_eff[i_rs3_addr])
                   | (i_rd_wen && w_pend_eff[i_rd_addr])
                   | (i_lu_op && w_full && !w_done_ok);

   assign o_busy = |r_pend;

   // Pending vector and in-flight count; a set beats a clear on the same register.
   always_ff @(posedge clk) begin
      if (!rst_n || i_clear) begin
         r_pend   <= '0;
         r_lu_cnt <= '0;
      end else begin
         r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;
         case ({i_issue, w_done_ok})
            2'b10:   r_lu_cnt <= r_lu_cnt + CNT_W'(1);
            2'b01:   r_lu_cnt <= r_lu_cnt - CNT_W'(1);
            default: r_lu_cnt <= r_lu_cnt;
         endcase
      end
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the IF/ID/EX/MEM/WB pipeline.
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int unsigned RF_ADDR_WIDTH = PSC_RF_ADDR_W,
   parameter int unsigned LU_DEPTH      = PSC_LU_DEPTH,
   parameter int unsigned TRAP_CYCLES   = PSC_TRAP_CYCLES
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_ld_use_req,
   input  logic                     i_icache_miss,
   input  logic                     i_dcache_busy,
   input  logic                     i_ex_redirect,
   input  logic                     i_trap_req,
   input  logic [RF_ADDR_WIDTH-1:0] i_id_rs1_addr,
   input  logic [RF_ADDR_WIDTH-1:0] i_id_rs2_addr,
   input  logic [RF_ADDR_WIDTH-1:0] i_id_rs3_addr,
   input  logic [RF_ADDR_WIDTH-1:0] i_id_rd_addr,
   input  logic                     i_id_rd_wen,
   input  logic                     i_id_lu_op,
   input  logic                     i_lu_done,
   input  logic [RF_ADDR_WIDTH-1:0] i_lu_done_rd,
   output logic                     o_pc_stall,
   output logic                     o_ifid_stall,
   output logic                     o_ifid_flush,
   output logic                     o_idex_stall,
   output logic                     o_idex_flush,
   output logic                     o_exmem_stall,
   output logic                     o_exmem_flush,
   output logic                     o_memwb_stall,
   output logic                     o_lu_issue,
   output logic                     o_lu_kill,
   output logic                     o_sb_busy
);

   localparam int unsigned TRAP_W = cnt_width(TRAP_CYCLES - 1);

   psc_state_e        r_state;
   psc_state_e        w_state_nxt;
   logic [TRAP_W-1:0] r_trap_cnt;
   logic [TRAP_W-1:0] w_trap_cnt_nxt;
   logic              r_redir_pend;
   logic              w_redir_pend_nxt;
   logic              w_redirect;
   logic              w_hazard;
   stage_ctrl_t       w_ctrl;

   pipe_scoreboard #(
      .RF_ADDR_WIDTH (RF_ADDR_WIDTH),
      .LU_DEPTH      (LU_DEPTH)
   ) u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clear    (i_trap_req),
      .i_issue    (w_ctrl.lu_issue),
      .i_done     (i_lu_done),
      .i_done_rd  (i_lu_done_rd),
      .i_rs1_addr (i_id_rs1_addr),
      .i_rs2_addr (i_id_rs2_addr),
      .i_rs3_addr (i_id_rs3_addr),
      .i_rd_addr  (i_id_rd_addr),
      .i_rd_wen   (i_id_rd_wen),
      .i_lu_op    (i_id_lu_op),
      .o_hazard   (w_hazard),
      .o_busy     (o_sb_busy)
   );

   // State, trap flush counter and deferred-redirect flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= PSC_RUN;
         r_trap_cnt   <= '0;
         r_redir_pend <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_trap_cnt   <= w_trap_cnt_nxt;
         r_redir_pend <= w_redir_pend_nxt;
      end
   end

   // A redirect held back by a busy D$ is replayed on the first free cycle.
   assign w_redirect = i_ex_redirect || ((r_state == PSC_MEM_WAIT) && r_redir_pend);

   // Next state and per-stage controls, highest-priority event first.
   always_comb begin
      w_ctrl           = '0;
      w_state_nxt      = r_state;
      w_trap_cnt_nxt   = r_trap_cnt;
      w_redir_pend_nxt = r_redir_pend;

      if (i_trap_req) begin
         w_ctrl.ifid_flush  = 1'b1;
         w_ctrl.idex_flush  = 1'b1;
         w_ctrl.exmem_flush = 1'b1;
         w_ctrl.lu_kill     = 1'b1;
         w_trap_cnt_nxt     = TRAP_W'(TRAP_CYCLES - 1);
         w_redir_pend_nxt   = 1'b0;
         w_state_nxt        = (TRAP_CYCLES > 1) ? PSC_TRAP_FLUSH : PSC_RUN;
      end else begin
         case (r_state)
            PSC_TRAP_FLUSH: begin
               w_ctrl.ifid_flush  = 1'b1;
               w_ctrl.idex_flush  = 1'b1;
               w_ctrl.exmem_flush = 1'b1;
               if (r_trap_cnt <= TRAP_W'(1)) begin
                  w_trap_cnt_nxt = '0;
                  w_state_nxt    = PSC_RUN;
               end else begin
                  w_trap_cnt_nxt = r_trap_cnt - TRAP_W'(1);
               end
            end
            PSC_RUN, PSC_MEM_WAIT: begin
               if (i_dcache_busy) begin
                  w_ctrl.pc_stall    = 1'b1;
                  w_ctrl.ifid_stall  = 1'b1;
                  w_ctrl.idex_stall  = 1'b1;
                  w_ctrl.exmem_stall = 1'b1;
                  w_ctrl.memwb_stall = 1'b1;
                  w_redir_pend_nxt   = r_redir_pend || i_ex_redirect;
                  w_state_nxt        = PSC_MEM_WAIT;
               end else begin
                  // The MEM_WAIT exit cycle is an ordinary RUN cycle.
                  w_state_nxt      = PSC_RUN;
                  w_redir_pend_nxt = 1'b0;
                  if (w_redirect) begin
                     w_ctrl.ifid_flush = 1'b1;
                     w_ctrl.idex_flush = 1'b1;
                  end else if (w_hazard || i_ld_use_req) begin
                     w_ctrl.pc_stall   = 1'b1;
                     w_ctrl.ifid_stall = 1'b1;
                     w_ctrl.idex_flush = 1'b1;
                  end else begin
                     if (i_icache_miss) begin
                        w_ctrl.pc_stall   = 1'b1;
                        w_ctrl.ifid_flush = 1'b1;
                     end
                     w_ctrl.lu_issue = i_id_lu_op && i_id_rd_wen;
                  end
               end
            end
            default: w_state_nxt = PSC_RUN;
         endcase
      end
   end

   assign o_pc_stall    = w_ctrl.pc_stall;
   assign o_ifid_stall  = w_ctrl.ifid_stall;
   assign o_ifid_flush  = w_ctrl.ifid_flush;
   assign o_idex_stall  = w_ctrl.idex_stall;
   assign o_idex_flush  = w_ctrl.idex_flush;
   assign o_exmem_stall = w_ctrl.exmem_stall;
   assign o_exmem_flush = w_ctrl.exmem_flush;
   assign o_memwb_stall = w_ctrl.memwb_stall;
   assign o_lu_issue    = w_ctrl.lu_issue;
   assign o_lu_kill     = w_ctrl.lu_kill;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; expected control vectors are queued then compared.
module tb_pipe_stall_ctrl;

   localparam logic [10:0] M_PC  = 11'h400;
   localparam logic [10:0] M_IFS = 11'h200;
   localparam logic [10:0] M_IFF = 11'h100;
   localparam logic [10:0] M_IDS = 11'h080;
   localparam logic [10:0] M_IDF = 11'h040;
   localparam logic [10:0] M_EMS = 11'h020;
   localparam logic [10:0] M_EMF = 11'h010;
   localparam logic [10:0] M_MWS = 11'h008;
   localparam logic [10:0] M_ISS = 11'h004;
   localparam logic [10:0] M_KIL = 11'h002;
   localparam logic [10:0] M_BSY = 11'h001;
   localparam logic [10:0] NONE  = 11'h000;
   localparam logic [10:0] HAZ   = M_PC | M_IFS | M_IDF;
   localparam logic [10:0] ALLS  = M_PC | M_IFS | M_IDS | M_EMS | M_MWS;
   localparam logic [10:0] TFL   = M_IFF | M_IDF | M_EMF;
   localparam logic [10:0] RDR   = M_IFF | M_IDF;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ld_use_req, icache_miss, dcache_busy, ex_redirect, trap_req;
   logic [4:0] rs1, rs2, rs3, rd, done_rd;
   logic       rd_wen, lu_op, lu_done;
   logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
   logic       exmem_stall, exmem_flush, memwb_stall, lu_issue, lu_kill, sb_busy;
   logic [10:0] obs;

   logic [10:0] q_exp[$];
   string       q_tag[$];
   int          n_total = 0;
   int          n_pass  = 0;

   always #5 clk = ~clk;

   pipe_stall_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_ld_use_req  (ld_use_req),
      .i_icache_miss (icache_miss),
      .i_dcache_busy (dcache_busy),
      .i_ex_redirect (ex_redirect),
      .i_trap_req    (trap_req),
      .i_id_rs1_addr (rs1),
      .i_id_rs2_addr (rs2),
      .i_id_rs3_addr (rs3),
      .i_id_rd_addr  (rd),
      .i_id_rd_wen   (rd_wen),
      .i_id_lu_op    (lu_op),
      .i_lu_done     (lu_done),
      .i_lu_done_rd  (done_rd),
      .o_pc_stall    (pc_stall),
      .o_ifid_stall  (ifid_stall),
      .o_ifid_flush  (ifid_flush),
      .o_idex_stall  (idex_stall),
      .o_idex_flush  (idex_flush),
      .o_exmem_stall (exmem_stall),
      .o_exmem_flush (exmem_flush),
      .o_memwb_stall (memwb_stall),
      .o_lu_issue    (lu_issue),
      .o_lu_kill     (lu_kill),
      .o_sb_busy     (sb_busy)
   );

   assign obs = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                 exmem_stall, exmem_flush, memwb_stall, lu_issue, lu_kill, sb_busy};

   task automatic idle();
      ld_use_req = 0; icache_miss = 0; dcache_busy = 0; ex_redirect = 0; trap_req = 0;
      rs1 = 0; rs2 = 0; rs3 = 0; rd = 0; rd_wen = 0; lu_op = 0; lu_done = 0; done_rd = 0;
   endtask

   // Queue the expectation for the inputs just driven, compare mid-cycle, then clock.
   task automatic step(input string tag, input logic [10:0] exp);
      logic [10:0] e;
      string       t;
      q_exp.push_back(exp);
      q_tag.push_back(tag);
      #2;
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      n_total++;
      assert (obs === e) n_pass++;
      else $error("FAIL %s: observed=%b expected=%b", t, obs, e);
      @(posedge clk); #1;
   endtask

   task automatic lu_issue_rd(input logic [4:0] r);
      idle(); lu_op = 1; rd_wen = 1; rd = r;
   endtask

   initial begin
      idle();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      step("reset", NONE);

      ld_use_req = 1;                 step("ld_use", HAZ);
      idle();                         step("ld_use_release", NONE);
      icache_miss = 1;                step("icache_miss", M_PC | M_IFF);
      idle(); ex_redirect = 1; ld_use_req = 1; icache_miss = 1;
                                      step("redirect_prio", RDR);

      // RAW on an in-flight long-latency result, then WAW, then same-cycle release.
      lu_issue_rd(5);                 step("lu_issue_rd5", M_ISS);
      idle(); rs1 = 5;                step("raw_stall_1", HAZ | M_BSY);
      idle(); rs3 = 5;                step("raw_stall_rs3", HAZ | M_BSY);
      idle(); rd = 5; rd_wen = 1;     step("waw_stall", HAZ | M_BSY);
      idle(); rs1 = 5; lu_done = 1; done_rd = 5;
                                      step("raw_release", M_BSY);
      idle();                         step("sb_empty", NONE);

      // Depth limit: third LU op waits, issues in the cycle a slot frees.
      lu_issue_rd(1);                 step("depth_issue1", M_ISS);
      lu_issue_rd(2);                 step("depth_issue2", M_ISS | M_BSY);
      lu_issue_rd(3);                 step("depth_full", HAZ | M_BSY);
      lu_issue_rd(3); lu_done = 1; done_rd = 1;
                                      step("depth_done_issue", M_ISS | M_BSY);
      idle();                         step("depth_pending", M_BSY);

      // Trap with two ops in flight.
      idle(); trap_req = 1;           step("trap_entry", TFL | M_KIL | M_BSY);
      idle();                         step("trap_flush2", TFL);
      idle();                         step("trap_done", NONE);
      idle(); rs1 = 2; rs2 = 3;       step("trap_sb_clear", NONE);
      lu_issue_rd(8);                 step("trap_cnt_clear", M_ISS);
      idle(); lu_done = 1; done_rd = 8;
                                      step("drain8", M_BSY);

      // Spurious write-back must not underflow the in-flight count.
      idle(); lu_done = 1; done_rd = 4;
                                      step("spurious_done", NONE);
      lu_issue_rd(10);                step("uf_issue1", M_ISS);
      lu_issue_rd(11);                step("uf_issue2", M_ISS | M_BSY);
      lu_issue_rd(12);                step("uf_full", HAZ | M_BSY);
      idle(); trap_req = 1;           step("trap_a", TFL | M_KIL | M_BSY);

      // Trap during flush restarts the count.
      idle(); trap_req = 1;           step("trap_restart", TFL | M_KIL);
      idle();                         step("trap_restart_fl", TFL);
      idle();                         step("trap_restart_end", NONE);

      // D$ busy for three cycles with a redirect in the second.
      idle(); dcache_busy = 1;        step("dbusy_1", ALLS);
      idle(); dcache_busy = 1; ex_redirect = 1;
                                      step("dbusy_2_redir", ALLS);
      idle(); dcache_busy = 1;        step("dbusy_3", ALLS);
      idle();                         step("dbusy_exit_redir", RDR);
      idle();                         step("dbusy_run", NONE);

      // Reset in MEM_WAIT with a pending register and a deferred redirect.
      lu_issue_rd(7);                 step("rst_issue7", M_ISS);
      idle(); dcache_busy = 1; ex_redirect = 1;
                                      step("rst_memwait", ALLS | M_BSY);
      idle(); rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      step("rst_outputs", NONE);
      idle(); rs1 = 7;                step("rst_sb_clear", NONE);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule
